// File: rtl/nf10_id_rom_arbiter.sv
// Round-robin arbiter sharing one ID ROM read port among C_NUM_REQ requesters.
// One transaction in flight: grant, ROM read, latency wait, held response.
module nf10_id_rom_arbiter #(
    parameter int C_NUM_REQ          = 4,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_ROM_ADDR_WIDTH   = 4,
    parameter int C_ROM_DEPTH        = 13,
    parameter int C_ROM_LATENCY      = 2
) (
    input  logic                                  S_AXI_ACLK,
    input  logic                                  S_AXI_ARESETN,
    input  logic [C_NUM_REQ-1:0]                  req_valid,
    input  logic [C_NUM_REQ*C_ROM_ADDR_WIDTH-1:0] req_addr,
    output logic [C_NUM_REQ-1:0]                  req_ready,
    output logic [C_NUM_REQ-1:0]                  rsp_valid,
    input  logic [C_NUM_REQ-1:0]                  rsp_ready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]         rsp_data,
    output logic                                  rsp_err,
    output logic                                  rom_en,
    output logic [C_ROM_ADDR_WIDTH-1:0]           rom_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]         rom_data,
    output logic                                  busy
);

    localparam int              GW      = $clog2(C_NUM_REQ);
    localparam int              AW      = C_ROM_ADDR_WIDTH;
    localparam logic [AW:0]     DEPTH_L = (AW+1)'(C_ROM_DEPTH);
    localparam logic [1:0]      LAT_L   = 2'(C_ROM_LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [GW-1:0] last_grant;
    logic [GW-1:0] gnt_p0;
    logic [AW-1:0] addr_p0;
    logic [1:0]    lat_cnt;

    logic          grant_any;
    logic [GW-1:0] grant_idx;
    logic [GW-1:0] scan_idx;
    logic [AW-1:0] grant_addr;
    logic          grant_in_range;
    logic          rsp_hs;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 1; k <= C_NUM_REQ; k++) begin
            scan_idx = GW'((int'(last_grant) + k) % C_NUM_REQ);
            if (!grant_any && req_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    assign grant_addr     = req_addr[grant_idx*AW +: AW];
    assign grant_in_range = ({1'b0, grant_addr} < DEPTH_L);
    assign rsp_hs         = (state == RESP) && rsp_ready[gnt_p0];
    assign rom_addr       = addr_p0;

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A grant is suppressed while reset is pending so it cannot be lost.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        rom_en    = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (grant_any && S_AXI_ARESETN) begin
                    req_ready[grant_idx] = 1'b1;
                    state_nxt            = grant_in_range ? READ : RESP;
                end
            end
            READ: begin
                rom_en    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (lat_cnt == LAT_L) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid[gnt_p0] = 1'b1;
                if (rsp_ready[gnt_p0]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture stage (grant) and response stage (ROM data / error) registers.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            last_grant <= GW'(C_NUM_REQ - 1);
            gnt_p0     <= '0;
            addr_p0    <= '0;
            lat_cnt    <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        gnt_p0  <= grant_idx;
                        addr_p0 <= grant_addr;
                        lat_cnt <= '0;
                        rsp_err <= !grant_in_range;
                        if (!grant_in_range) begin
                            rsp_data <= '0;
                        end
                    end
                end
                READ: begin
                    lat_cnt <= 2'd1;
                end
                WAIT: begin
                    if (lat_cnt == LAT_L) begin
                        rsp_data <= rom_data;
                        lat_cnt  <= '0;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        last_grant <= gnt_p0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nf10_id_rom_arbiter.sv
// Randomized scoreboard bench for nf10_id_rom_arbiter with a cycle-count
// reference model of grants, latency and held responses.
module tb_nf10_id_rom_arbiter;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 13;
    localparam int LAT   = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready = '0;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic            rom_en;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_data;
    logic            busy;

    always #5 clk = ~clk;

    nf10_id_rom_arbiter #(
        .C_NUM_REQ(N), .C_S_AXI_DATA_WIDTH(DW), .C_ROM_ADDR_WIDTH(AW),
        .C_ROM_DEPTH(DEPTH), .C_ROM_LATENCY(LAT)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_data(rom_data), .busy(busy)
    );

    // ROM model: data valid exactly LAT cycles after the enable cycle, junk otherwise.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    bit            pv [1:3];
    logic [AW-1:0] pa [1:3];
    logic [DW-1:0] junk = 32'h5A5A_5A5A;
    always @(posedge clk) begin
        pv[1] <= rom_en;  pa[1] <= rom_addr;
        pv[2] <= pv[1];   pa[2] <= pa[1];
        pv[3] <= pv[2];   pa[3] <= pa[2];
        junk  <= $urandom;
    end
    assign rom_data = pv[LAT] ? mem[pa[LAT]] : junk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    typedef struct {
        int            req;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   gnt_log[$];

    // Monitor / reference model
    bit            m_busy = 1'b0;
    int            m_last = N - 1;
    int            m_g = 0;
    int            m_gcyc = 0;
    int            m_due = 0;
    bit            m_ok = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] h_data = '0;
    logic          h_err = 1'b0;
    int            cyc = 0;

    initial begin
        int           g;
        int           fi;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_vld;
        bit           exp_en;
        repeat (2) @(posedge clk);
        forever begin
            @(negedge clk);
            cyc++;
            g = -1;
            exp_rdy = '0;
            if (!m_busy && rst_n) begin
                for (int k = 1; k <= N; k++) begin
                    if (g < 0 && req_valid[(m_last + k) % N]) g = (m_last + k) % N;
                end
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            chk("busy", 64'(busy), 64'(m_busy));
            exp_en = m_busy && m_ok && (cyc == m_gcyc + 1);
            chk("rom_en", 64'(rom_en), 64'(exp_en));
            chk("rom_addr", 64'(rom_addr), 64'(m_addr));
            exp_vld = '0;
            if (m_busy && cyc >= m_due) exp_vld[m_g] = 1'b1;
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_vld));
            if (m_busy && cyc == m_due) begin
                fi = -1;
                for (int k = 0; k < exp_q.size(); k++) begin
                    if (fi < 0 && exp_q[k].req == m_g) fi = k;
                end
                chk("sb_entry", 64'(fi >= 0), 64'd1);
                if (fi >= 0) begin
                    chk("rsp_data", 64'(rsp_data), 64'(exp_q[fi].data));
                    chk("rsp_err", 64'(rsp_err), 64'(exp_q[fi].err));
                    exp_q.delete(fi);
                end
                h_data = rsp_data;
                h_err  = rsp_err;
            end else if (m_busy && cyc > m_due) begin
                chk("rsp_data_hold", 64'(rsp_data), 64'(h_data));
                chk("rsp_err_hold", 64'(rsp_err), 64'(h_err));
            end
            if (!rst_n) begin
                m_busy = 1'b0;
                m_last = N - 1;
                m_addr = '0;
                exp_q.delete();
            end else if (g >= 0) begin
                m_busy = 1'b1;
                m_g    = g;
                m_addr = req_addr[g*AW +: AW];
                m_ok   = (int'(m_addr) < DEPTH);
                m_gcyc = cyc;
                m_due  = cyc + (m_ok ? LAT + 2 : 1);
                gnt_log.push_back(g);
            end else if (m_busy && cyc >= m_due && rsp_ready[m_g]) begin
                m_busy = 1'b0;
                m_last = m_g;
            end
        end
    end

    // Driver
    logic [N-1:0] last_acc = '0;

    task automatic step();
        @(negedge clk);
        last_acc = req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (last_acc[i]) req_valid[i] = 1'b0;
    endtask

    task automatic raise(input int i, input logic [AW-1:0] a);
        exp_t e;
        req_valid[i] = 1'b1;
        req_addr[i*AW +: AW] = a;
        e.req  = i;
        e.err  = (int'(a) >= DEPTH);
        e.data = e.err ? '0 : mem[a];
        exp_q.push_back(e);
    endtask

    task automatic withdraw(input int i);
        int fi;
        req_valid[i] = 1'b0;
        fi = -1;
        for (int k = exp_q.size() - 1; k >= 0; k--) begin
            if (fi < 0 && exp_q[k].req == i) fi = k;
        end
        if (fi >= 0) exp_q.delete(fi);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        step();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_rom_en", 64'(rom_en), 64'd0);
        chk("rst_rom_addr", 64'(rom_addr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        step();
        rst_n = 1'b1;
        gnt_log.delete();
    endtask

    task automatic wait_rsp(input int i, input string name);
        int b;
        for (b = 0; b < 30 && !rsp_valid[i]; b++) step();
        chk(name, 64'(rsp_valid[i]), 64'd1);
    endtask

    task automatic drain();
        int b;
        rsp_ready = '1;
        for (b = 0; b < 300 && (req_valid != 0 || busy || exp_q.size() != 0); b++) step();
        chk("drain_done", 64'(b < 300), 64'd1);
    endtask

    initial begin
        int            b;
        logic [DW-1:0] d0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        mem[2] = 32'h0A0B_0C0D;
        do_reset();

        // Single valid request
        raise(0, 4'd2);
        wait_rsp(0, "single_rsp");
        chk("single_data", 64'(rsp_data), 64'h0A0B_0C0D);
        chk("single_err", 64'(rsp_err), 64'd0);
        drain();

        // Invalid address
        rsp_ready = '0;
        raise(2, 4'd14);
        wait_rsp(2, "inv_rsp");
        chk("inv_data", 64'(rsp_data), 64'd0);
        chk("inv_err", 64'(rsp_err), 64'd1);
        drain();

        // Backpressure with a stray rsp_ready on another requester
        rsp_ready = '0;
        raise(1, 4'd5);
        wait_rsp(1, "bp_rsp");
        d0 = rsp_data;
        raise(0, 4'd7);
        rsp_ready = 4'b1000;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("bp_valid", 64'(rsp_valid), 64'b0010);
            chk("bp_data", 64'(rsp_data), 64'(d0));
            chk("bp_busy", 64'(busy), 64'd1);
            chk("bp_no_grant", 64'(last_acc), 64'd0);
        end
        rsp_ready = 4'b0010;
        step();
        chk("bp_release_idle", 64'(busy), 64'd0);
        drain();

        // All requesters continuously after reset
        do_reset();
        rsp_ready = '1;
        for (int c = 0; c < 24; c++) begin
            for (int i = 0; i < N; i++) if (!req_valid[i]) raise(i, AW'($urandom_range(0, DEPTH - 1)));
            step();
        end
        drain();
        chk("rr_count", 64'(gnt_log.size() >= 8), 64'd1);
        for (int k = 0; k < 8 && k < gnt_log.size(); k++) chk("rr_order", 64'(gnt_log[k]), 64'(k % 4));

        // Reset during WAIT
        rsp_ready = '1;
        raise(3, 4'd4);
        last_acc = '0;
        for (b = 0; b < 20 && !last_acc[3]; b++) step();
        chk("w_grant", 64'(b < 20), 64'd1);
        step();
        do_reset();
        repeat (4) step();
        chk("w_no_rsp", 64'(rsp_valid), 64'd0);
        raise(2, 4'd3);
        raise(0, 4'd1);
        drain();
        chk("w_first", 64'(gnt_log.size() > 0 ? gnt_log[0] : -1), 64'd0);
        chk("w_second", 64'(gnt_log.size() > 1 ? gnt_log[1] : -1), 64'd2);

        // Randomized traffic with withdrawals and random response acceptance
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 99) < 30) raise(i, AW'($urandom_range(0, 15)));
                end else if ($urandom_range(0, 99) < 5) begin
                    withdraw(i);
                end
            end
            rsp_ready = N'($urandom);
            step();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/nf10_id_rom_arbiter.md
NF10_ID_ROM_ARBITER -- requirements
Module: nf10_id_rom_arbiter

Interface
REQ-001 Parameter C_NUM_REQ, default 4, number of requesters sharing the ID ROM read port (2..8).
REQ-002 Parameter C_S_AXI_DATA_WIDTH, default 32, ROM word and response data width.
REQ-003 Parameter C_ROM_ADDR_WIDTH, default 4, word-address width of the ROM.
REQ-004 Parameter C_ROM_DEPTH, default 13, number of populated words (0x00-0x30 byte range).
REQ-005 Parameter C_ROM_LATENCY, default 2, cycles from rom_en to valid rom_data (1..3).
REQ-006 S_AXI_ACLK  in  1  sole clock; all logic on rising edge.
REQ-007 S_AXI_ARESETN  in  1  reset, synchronous, active-low.
REQ-008 req_valid  in  C_NUM_REQ  per-requester read request; held until accepted.
REQ-009 req_addr  in  C_NUM_REQ*C_ROM_ADDR_WIDTH  word address, requester i in slice i.
REQ-010 req_ready  out  C_NUM_REQ  one-hot accept pulse, one cycle.
REQ-011 rsp_valid  out  C_NUM_REQ  one-hot response valid, held until rsp_ready.
REQ-012 rsp_ready  in  C_NUM_REQ  per-requester response accept.
REQ-013 rsp_data  out  C_S_AXI_DATA_WIDTH  shared response data, meaningful while any rsp_valid.
REQ-014 rsp_err  out  1  set with rsp_valid when address >= C_ROM_DEPTH.
REQ-015 rom_en  out  1  ROM read enable.
REQ-016 rom_addr  out  C_ROM_ADDR_WIDTH  ROM word address.
REQ-017 rom_data  in  C_S_AXI_DATA_WIDTH  ROM read data.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 FSM states SHALL be IDLE, READ, WAIT, RESP; exactly one transaction in flight.
REQ-020 IDLE with any req_valid: grant chosen round-robin, searching from (last_grant+1) mod C_NUM_REQ upward; req_ready[g] asserted combinationally that cycle; address and g captured.
REQ-021 IDLE grant with captured address < C_ROM_DEPTH -> READ; otherwise -> RESP with rsp_data=0, rsp_err=1, no ROM access.
REQ-022 READ lasts one cycle: rom_en=1, rom_addr=captured address; -> WAIT.
REQ-023 WAIT counts C_ROM_LATENCY cycles after the rom_en cycle; rom_data registered in the cycle it is valid; -> RESP.
REQ-024 rom_en SHALL be 0 in all states except READ; rom_addr SHALL hold the last captured address.
REQ-025 RESP: rsp_valid[g]=1, rsp_data and rsp_err stable until rsp_ready[g]; on rsp_valid[g]&&rsp_ready[g] -> IDLE, last_grant<=g.
REQ-026 Latency: rsp_valid rises exactly C_ROM_LATENCY+2 cycles after the grant cycle (valid address), 1 cycle after (invalid address).
REQ-027 Throughput: new grant no earlier than the cycle after response handshake; back-to-back requests from all requesters each served once per rotation.
REQ-028 rsp_ready for a non-granted requester, or outside RESP, SHALL be ignored.
REQ-029 req_valid deasserted before acceptance SHALL be treated as withdrawn (no grant).
REQ-030 rsp_err SHALL be 0 for valid-address responses.

Reset
REQ-031 On S_AXI_ARESETN=0 at a clock edge: state<=IDLE, last_grant<=C_NUM_REQ-1 (requester 0 highest priority first), req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, rom_en=0, rom_addr=0, busy=0, latency counter=0.
REQ-032 Reset mid-transaction SHALL abandon it; ROM data arriving after reset SHALL be discarded; no response issued.

Verification
REQ-033 Single request: req_valid[0]=1, addr=2, ROM word2=0x0A0B0C0D, latency 2 -> req_ready[0] one cycle, rom_en one cycle with rom_addr=2, rsp_valid[0] 4 cycles after grant, rsp_data=0x0A0B0C0D, rsp_err=0.
REQ-034 All four requesting continuously after reset, rsp_ready tied 1 -> grant order 0,1,2,3,0 with no requester served twice before others.
REQ-035 Invalid address: req_valid[2]=1, addr=14 -> rom_en never asserted, rsp_valid[2] next cycle, rsp_data=0, rsp_err=1.
REQ-036 Response backpressure: rsp_ready[1]=0 for 10 cycles -> rsp_valid[1] and rsp_data stable, busy=1, no new req_ready; rsp_ready[1]=1 -> IDLE next cycle.
REQ-037 Reset asserted during WAIT -> next cycle all outputs zero, state IDLE; late rom_data produces no rsp_valid; next request granted to requester 0 first.
REQ-038 Stray rsp_ready[3]=1 while requester 1 in RESP -> no effect; rsp_valid[1] remains until rsp_ready[1].
